// File: rtl/wb_dcache_controller.sv
// Sequencing FSM for the write-back data cache and its victim cache: lookup, hit completion,
// victim refill, dirty writeback, line allocation and full-cache clean (flush) walks.
module wb_dcache_controller #(
  parameter int unsigned DCACHE_IDX_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lsummu2dcache_req_i,
  input  logic                       lsummu2dcache_wr_i,
  input  logic                       dcache_flush_i,
  output logic                       dcache2lsummu_ack_o,
  output logic                       dcache_flush_ack_o,
  input  logic                       cache_hit_i,
  input  logic                       cache_evict_req_i,
  input  logic                       dcache_valid_i,
  input  logic                       victim_hit_i,
  input  logic                       mem2dcache_ack_i,
  output logic                       dcache2mem_req_o,
  output logic                       dcache2mem_wr_o,
  output logic                       dcache_ram_req_o,
  output logic                       cache_wr_o,
  output logic                       cache_line_wr_o,
  output logic                       cache_line_clean_o,
  output logic                       cache_wrb_req_o,
  output logic                       victim_wr_en_o,
  output logic                       victim2dcache_wr_en_o,
  output logic                       dcache_victim_sel_o,
  output logic                       dcache_flush_o,
  output logic [DCACHE_IDX_BITS-1:0] evict_index_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_VFILL, S_WRBACK, S_ALLOC, S_REFETCH,
    S_FL_RD, S_FL_CHK, S_FL_WB, S_FL_NEXT
  } state_e;

  localparam logic [DCACHE_IDX_BITS-1:0] IDX_LAST = '1;

  state_e                     state_q, state_d;
  logic [DCACHE_IDX_BITS-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dcache_flush_i)           state_d = S_FL_RD;
        else if (lsummu2dcache_req_i) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cache_hit_i)            state_d = S_IDLE;
        else if (victim_hit_i)      state_d = S_VFILL;
        else if (cache_evict_req_i) state_d = S_WRBACK;
        else                        state_d = S_ALLOC;
      end
      S_VFILL:   state_d = S_LOOKUP;
      S_WRBACK:  if (mem2dcache_ack_i) state_d = S_ALLOC;
      S_ALLOC:   if (mem2dcache_ack_i) state_d = S_REFETCH;
      S_REFETCH: state_d = S_LOOKUP;
      S_FL_RD:   state_d = S_FL_CHK;
      S_FL_CHK:  state_d = cache_evict_req_i ? S_FL_WB : S_FL_NEXT;
      S_FL_WB:   if (mem2dcache_ack_i) state_d = S_FL_NEXT;
      S_FL_NEXT: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FL_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mem-ack-qualified strobes only fire in states that hold dcache2mem_req_o, so stray acks are inert.
  always_comb begin
    dcache2lsummu_ack_o   = 1'b0;
    dcache_flush_ack_o    = 1'b0;
    dcache2mem_req_o      = 1'b0;
    dcache2mem_wr_o       = 1'b0;
    dcache_ram_req_o      = 1'b0;
    cache_wr_o            = 1'b0;
    cache_line_wr_o       = 1'b0;
    cache_line_clean_o    = 1'b0;
    cache_wrb_req_o       = 1'b0;
    victim_wr_en_o        = 1'b0;
    victim2dcache_wr_en_o = 1'b0;
    dcache_victim_sel_o   = 1'b0;
    dcache_flush_o        = 1'b0;
    case (state_q)
      S_IDLE: dcache_ram_req_o = lsummu2dcache_req_i & ~dcache_flush_i;
      S_LOOKUP: begin
        if (cache_hit_i) begin
          dcache2lsummu_ack_o = 1'b1;
          cache_wr_o          = lsummu2dcache_wr_i;
        end else if (!victim_hit_i && !cache_evict_req_i && dcache_valid_i) begin
          victim_wr_en_o = 1'b1;
        end
      end
      S_VFILL: begin
        victim2dcache_wr_en_o = 1'b1;
        dcache_victim_sel_o   = 1'b1;
        dcache_ram_req_o      = 1'b1;
      end
      S_WRBACK: begin
        dcache2mem_req_o = 1'b1;
        dcache2mem_wr_o  = 1'b1;
        cache_wrb_req_o  = 1'b1;
        victim_wr_en_o   = mem2dcache_ack_i;
      end
      S_ALLOC: begin
        dcache2mem_req_o = 1'b1;
        cache_line_wr_o  = mem2dcache_ack_i;
      end
      S_REFETCH: dcache_ram_req_o = 1'b1;
      S_FL_RD: begin
        dcache_flush_o   = 1'b1;
        dcache_ram_req_o = 1'b1;
      end
      S_FL_CHK: dcache_flush_o = 1'b1;
      S_FL_WB: begin
        dcache_flush_o     = 1'b1;
        dcache2mem_req_o   = 1'b1;
        dcache2mem_wr_o    = 1'b1;
        cache_wrb_req_o    = 1'b1;
        cache_line_clean_o = mem2dcache_ack_i;
      end
      S_FL_NEXT: begin
        dcache_flush_o     = 1'b1;
        dcache_flush_ack_o = (idx_q == IDX_LAST);
      end
      default: ;
    endcase
  end

  assign evict_index_o = idx_q;

endmodule

// File: tb/tb_wb_dcache_controller.sv
// Directed bench: per-transaction expected output traces built from the controller's rules,
// checked cycle by cycle against the DUT while a small LSU/datapath/memory environment responds.
module tb_wb_dcache_controller;

  localparam int IDX = 2;
  typedef logic [14:0] word_t;

  localparam word_t ACK  = 15'h4000, FACK = 15'h2000, MREQ = 15'h1000, MWR  = 15'h0800;
  localparam word_t RAM  = 15'h0400, CWR  = 15'h0200, LWR  = 15'h0100, CLN  = 15'h0080;
  localparam word_t WRB  = 15'h0040, VWR  = 15'h0020, V2D  = 15'h0010, VSEL = 15'h0008;
  localparam word_t FL   = 15'h0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, req = 1'b0, wr = 1'b0, flush = 1'b0;
  logic ack_o, fack_o, mreq_o, mwr_o, ram_o, cwr_o, lwr_o, cln_o, wrb_o, vwr_o, v2d_o, vsel_o, fl_o;
  logic [IDX-1:0] eidx_o;
  logic hit_i, dirty_i, valid_i, vhit_i, mack_i;

  // environment state
  logic acc_hit = 0, acc_vh = 0, acc_dirty = 0, acc_valid = 0, ack_force = 0;
  logic [3:0] fl_dirty = '0;
  logic filled = 0, mack_r = 0;
  int   lat_r = 1, mcnt = 0;
  logic ack_seen = 0, fack_seen = 0;

  assign hit_i   = acc_hit | filled;
  assign vhit_i  = acc_vh & ~filled;
  assign dirty_i = fl_o ? fl_dirty[eidx_o] : acc_dirty;
  assign valid_i = acc_valid;
  assign mack_i  = mack_r | ack_force;

  wb_dcache_controller #(.DCACHE_IDX_BITS(IDX)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsummu2dcache_req_i(req), .lsummu2dcache_wr_i(wr), .dcache_flush_i(flush),
    .dcache2lsummu_ack_o(ack_o), .dcache_flush_ack_o(fack_o),
    .cache_hit_i(hit_i), .cache_evict_req_i(dirty_i), .dcache_valid_i(valid_i),
    .victim_hit_i(vhit_i), .mem2dcache_ack_i(mack_i),
    .dcache2mem_req_o(mreq_o), .dcache2mem_wr_o(mwr_o), .dcache_ram_req_o(ram_o),
    .cache_wr_o(cwr_o), .cache_line_wr_o(lwr_o), .cache_line_clean_o(cln_o),
    .cache_wrb_req_o(wrb_o), .victim_wr_en_o(vwr_o), .victim2dcache_wr_en_o(v2d_o),
    .dcache_victim_sel_o(vsel_o), .dcache_flush_o(fl_o), .evict_index_o(eidx_o)
  );

  // memory: acks after lat_r cycles of a held request
  always @(posedge clk) begin
    #3;
    if (mreq_o) begin
      mcnt   = mcnt + 1;
      mack_r = (mcnt >= lat_r);
      if (mack_r) mcnt = 0;
    end else begin
      mack_r = 0;
      mcnt   = 0;
    end
  end

  // datapath: requested line becomes present once filled from memory or victim cache
  always @(posedge clk) begin
    if (!rst_n || ack_o) filled = 0;
    else if (lwr_o || v2d_o) filled = 1;
  end

  word_t exp_q[$], gen_q[$];
  int checks = 0, errors = 0;

  function automatic word_t dut_word();
    return {ack_o, fack_o, mreq_o, mwr_o, ram_o, cwr_o, lwr_o, cln_o, wrb_o,
            vwr_o, v2d_o, vsel_o, fl_o, eidx_o};
  endfunction

  task automatic push(input word_t w);
    gen_q.push_back(w);
  endtask

  task automatic gen_access(input bit st, input bit hit, input bit vh, input bit dirty,
                            input bit valid, input int lat);
    word_t cw = st ? CWR : '0;
    push(RAM);
    if (hit) push(ACK | cw);
    else if (vh) begin
      push('0); push(V2D | VSEL | RAM); push(ACK | cw);
    end else begin
      push((valid && !dirty) ? VWR : '0);
      if (dirty) begin
        for (int i = 0; i < lat - 1; i++) push(MREQ | MWR | WRB);
        push(MREQ | MWR | WRB | VWR);
      end
      for (int i = 0; i < lat - 1; i++) push(MREQ);
      push(MREQ | LWR);
      push(RAM);
      push(ACK | cw);
    end
  endtask

  task automatic gen_flush(input logic [3:0] dmask, input int lat);
    push('0);
    for (int i = 0; i < 4; i++) begin
      word_t ix = word_t'(i);
      push(RAM | FL | ix);
      push(FL | ix);
      if (dmask[i]) begin
        for (int k = 0; k < lat - 1; k++) push(MREQ | MWR | WRB | FL | ix);
        push(MREQ | MWR | WRB | CLN | FL | ix);
      end
      push(FL | ix | ((i == 3) ? FACK : '0));
    end
  endtask

  task automatic commit();
    while (gen_q.size() > 0) exp_q.push_back(gen_q.pop_front());
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // compare process: model pins first, then every queued cycle against the DUT
  initial begin
    word_t e;
    gen_access(0, 1, 0, 0, 0, 1);
    pin("pin_loadhit_len", gen_q.size(), 2);
    pin("pin_loadhit_ack", int'(gen_q[1]), 'h4000);
    gen_q.delete();
    gen_access(1, 0, 0, 0, 1, 2);
    pin("pin_miss_len", gen_q.size(), 6);
    pin("pin_miss_ack", int'(gen_q[5]), 'h4200);
    gen_q.delete();
    gen_flush(4'b1010, 1);
    pin("pin_flush_len", gen_q.size(), 15);
    pin("pin_flush_last", int'(gen_q[14]), 'h2007);
    gen_q.delete();
    forever begin
      @(negedge clk);
      ack_seen  = ack_o;
      fack_seen = fack_o;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_word() !== e) begin
          errors++;
          $display("FAIL trace @%0t: got %h required %h", $time, dut_word(), e);
        end
        checks++;
        if ($countones({cwr_o, lwr_o, v2d_o, cln_o}) > 1 || (vwr_o && v2d_o)) begin
          errors++;
          $display("FAIL mutex @%0t: got %h required exclusive strobes", $time, dut_word());
        end
      end
    end
  end

  task automatic drain(input string name);
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #2;
      if (ack_seen)  req   = 0;
      if (fack_seen) flush = 0;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: got %0d pending cycles required 0", name, exp_q.size());
      exp_q.delete();
      req = 0; flush = 0;
    end
    push('0); commit();
  endtask

  task automatic run_access(input string name, input bit st, input bit hit, input bit vh,
                            input bit dirty, input bit valid, input int lat);
    @(posedge clk); #2;
    acc_hit = hit; acc_vh = vh; acc_dirty = dirty; acc_valid = valid; lat_r = lat;
    req = 1; wr = st;
    gen_access(st, hit, vh, dirty, valid, lat); commit();
    drain(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2; push('0); commit();
    @(posedge clk); #2;
    rst_n = 1;

    run_access("load_hit",         0, 1, 0, 0, 1, 1);
    run_access("store_hit",        1, 1, 0, 0, 1, 1);
    run_access("store_miss_dirty", 1, 0, 0, 1, 1, 4);
    run_access("load_victim",      0, 0, 1, 0, 1, 1);
    run_access("load_miss_clean",  0, 0, 0, 0, 1, 1);
    run_access("store_miss_inval", 1, 0, 0, 0, 0, 3);

    // flush walk with lines 1 and 3 dirty
    @(posedge clk); #2;
    fl_dirty = 4'b1010; lat_r = 2; flush = 1;
    gen_flush(4'b1010, 2); commit();
    drain("flush");

    // flush and load together: flush first, then the load hit
    @(posedge clk); #2;
    fl_dirty = 4'b0001; lat_r = 1; acc_hit = 1; acc_vh = 0; acc_dirty = 0; acc_valid = 1;
    flush = 1; req = 1; wr = 0;
    gen_flush(4'b0001, 1); gen_access(0, 1, 0, 0, 1, 1); commit();
    drain("flush_then_req");

    // reset during ALLOC, then a stray memory ack in IDLE
    @(posedge clk); #2;
    acc_hit = 0; acc_vh = 0; acc_dirty = 0; acc_valid = 1; lat_r = 8;
    req = 1; wr = 0;
    push(RAM); push(VWR); push(MREQ); push(MREQ); push('0); push('0); push('0); push('0);
    commit();
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 0; req = 0;
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;
    ack_force = 1;
    @(posedge clk); #2;
    ack_force = 0;
    drain("reset_alloc");

    run_access("post_reset_hit", 1, 1, 0, 0, 1, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
